element_op_seq: RTL and testbench

Sequencer that runs one element-wise matrix op (add/sub/mul/div/mod) over the active region of two operand matrices, one element per cycle, through a single shared 32-bit element ALU.
- Accepts a command, checks operand sizes and op code, walks the active region in row-major order, reads operand pairs from the matrix store, and writes results back.
- Sits between the top-level command decoder and the matrix register store; replaces instantiating WIDTH*WIDTH parallel dividers.

---
 rtl/element_op_seq_pkg.sv | 34 +++
 rtl/element_op_seq_if.sv | 46 ++++
 rtl/element_op_seq_alu.sv | 43 ++++
 rtl/element_op_seq.sv | 152 +++++++++++++++
 tb/tb_element_op_seq.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/element_op_seq_pkg.sv
// element_op_pkg - op/err codes, sequencer state type and default widths.
// Revision: 1.0
`default_nettype none

package element_op_pkg;

  localparam int WIDTH_BIT_DEF = 2;
  localparam int DATA_W_DEF    = 32;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;
  localparam logic [2:0] OP_MOD = 3'd4;

  localparam logic [1:0] ERR_OK   = 2'd0;
  localparam logic [1:0] ERR_SIZE = 2'd1;
  localparam logic [1:0] ERR_OP   = 2'd2;
  localparam logic [1:0] ERR_DIV0 = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic logic op_legal(input logic [2:0] op);
    return (op <= OP_MOD);
  endfunction

endpackage

`default_nettype wire

// File: rtl/element_op_seq_if.sv
// element_op_seq_if - command and matrix-store port bundle of the sequencer.
// Revision: 1.0
`default_nettype none

interface element_op_seq_if #(
  parameter int WIDTH_BIT = element_op_pkg::WIDTH_BIT_DEF,
  parameter int DATA_W    = element_op_pkg::DATA_W_DEF
);

  logic                          cmd_valid;
  logic                          cmd_ready;
  logic [2:0]                    cmd_op;
  logic [0:1][WIDTH_BIT-1:0]     cmd_size_a;
  logic [0:1][WIDTH_BIT-1:0]     cmd_size_b;

  logic                          rd_en;
  logic [WIDTH_BIT-1:0]          rd_row;
  logic [WIDTH_BIT-1:0]          rd_col;
  logic [DATA_W-1:0]             rd_a_data;
  logic [DATA_W-1:0]             rd_b_data;

  logic                          wr_en;
  logic [WIDTH_BIT-1:0]          wr_row;
  logic [WIDTH_BIT-1:0]          wr_col;
  logic [DATA_W-1:0]             wr_data;

  logic                          busy;
  logic                          done;
  logic [1:0]                    err_code;

  // master: the sequencer itself; slave: decoder plus matrix store.
  modport master (
    input  cmd_valid, cmd_op, cmd_size_a, cmd_size_b, rd_a_data, rd_b_data,
    output cmd_ready, rd_en, rd_row, rd_col, wr_en, wr_row, wr_col, wr_data,
           busy, done, err_code
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_size_a, cmd_size_b, rd_a_data, rd_b_data,
    input  cmd_ready, rd_en, rd_row, rd_col, wr_en, wr_row, wr_col, wr_data,
           busy, done, err_code
  );

endinterface

`default_nettype wire

// File: rtl/element_op_seq_alu.sv
// element_alu - combinational unsigned add/sub/mul/div/mod on one element.
// Revision: 1.0
`default_nettype none

module element_alu
  import element_op_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [2:0]        op,
  output logic [DATA_W-1:0] result,
  output logic              div0
);

  logic b_zero;

  assign b_zero = (b == '0);

  always_comb begin
    result = '0;
    div0   = 1'b0;
    case (op)
      OP_ADD: result = a + b;
      OP_SUB: result = a - b;
      OP_MUL: result = a * b;
      // Zero divisor substitutes: all-ones quotient, dividend as remainder.
      OP_DIV: begin
        div0   = b_zero;
        result = b_zero ? '1 : a / b;
      end
      OP_MOD: begin
        div0   = b_zero;
        result = b_zero ? a : a % b;
      end
      default: result = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/element_op_seq.sv
// element_op_seq - walks the active region row-major through one shared element ALU.
// Revision: 1.0. Optional macro ELEMENT_OP_DIV0_ABORT_EN stops at the first zero divisor.
`default_nettype none

module element_op_seq
  import element_op_pkg::*;
#(
  parameter int WIDTH_BIT = WIDTH_BIT_DEF,
  parameter int DATA_W    = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  element_op_seq_if.master  bus
);

  state_t               state;
  state_t               state_nxt;

  logic [2:0]           op_q;
  logic [WIDTH_BIT-1:0] rows;
  logic [WIDTH_BIT-1:0] cols;
  logic [WIDTH_BIT-1:0] row;
  logic [WIDTH_BIT-1:0] col;
  logic [WIDTH_BIT-1:0] wr_row_q;
  logic [WIDTH_BIT-1:0] wr_col_q;
  logic                 wr_pend;
  logic [1:0]           err_q;

  logic                 accept;
  logic                 size_ok;
  logic                 op_ok;
  logic                 last;
  logic                 rd_go;
  logic                 abort;
  logic [DATA_W-1:0]    alu_result;
  logic                 alu_div0;

  assign accept  = bus.cmd_valid && (state == ST_IDLE);
  assign size_ok = (bus.cmd_size_a == bus.cmd_size_b);
  assign op_ok   = op_legal(bus.cmd_op);
  assign last    = (row == rows) && (col == cols);

  // Operands arrive one cycle after the read, so the ALU always serves the pending write.
  element_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .a      (bus.rd_a_data),
    .b      (bus.rd_b_data),
    .op     (op_q),
    .result (alu_result),
    .div0   (alu_div0)
  );

`ifdef ELEMENT_OP_DIV0_ABORT_EN
  assign abort = wr_pend && alu_div0;
`else
  assign abort = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    rd_go     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_nxt = (size_ok && op_ok) ? ST_RUN : ST_DONE;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_nxt = ST_DONE;
        end else begin
          rd_go = 1'b1;
          if (last) begin
            state_nxt = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q     <= OP_ADD;
      rows     <= '0;
      cols     <= '0;
      row      <= '0;
      col      <= '0;
      wr_row_q <= '0;
      wr_col_q <= '0;
      wr_pend  <= 1'b0;
      err_q    <= ERR_OK;
    end else begin
      wr_pend <= rd_go;
      if (rd_go) begin
        wr_row_q <= row;
        wr_col_q <= col;
        if (col == cols) begin
          col <= '0;
          row <= row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
      if (accept) begin
        op_q <= bus.cmd_op;
        rows <= bus.cmd_size_a[0];
        cols <= bus.cmd_size_a[1];
        row  <= '0;
        col  <= '0;
        if (!size_ok) begin
          err_q <= ERR_SIZE;
        end else if (!op_ok) begin
          err_q <= ERR_OP;
        end else begin
          err_q <= ERR_OK;
        end
      end else if (wr_pend && alu_div0) begin
        // Sticky: once a zero divisor is seen the command reports it at done.
        err_q <= ERR_DIV0;
      end
    end
  end

  assign bus.cmd_ready = (state == ST_IDLE);
  assign bus.busy      = (state != ST_IDLE);
  assign bus.done      = (state == ST_DONE);
  assign bus.err_code  = err_q;

  assign bus.rd_en     = rd_go;
  assign bus.rd_row    = rd_go ? row : '0;
  assign bus.rd_col    = rd_go ? col : '0;

  assign bus.wr_en     = wr_pend && !abort;
  assign bus.wr_row    = bus.wr_en ? wr_row_q : '0;
  assign bus.wr_col    = bus.wr_en ? wr_col_q : '0;
  assign bus.wr_data   = bus.wr_en ? alu_result : '0;

endmodule

`default_nettype wire

// File: tb/tb_element_op_seq.sv
// tb_element_op_seq - directed and random commands checked against a matrix-level model.
// Revision: 1.0
`timescale 1ns/1ps
`default_nettype none

module tb_element_op_seq;
  import element_op_pkg::*;

  localparam int WB = 2;
  localparam int DW = 32;
  localparam int W  = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  element_op_seq_if #(.WIDTH_BIT(WB), .DATA_W(DW)) bus ();

  element_op_seq #(.WIDTH_BIT(WB), .DATA_W(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  logic [DW-1:0] mem_a [W][W];
  logic [DW-1:0] mem_b [W][W];

  int vectors     = 0;
  int miscompares = 0;

  int nxt_op, nxt_ra, nxt_ca, nxt_rb, nxt_cb;

  typedef struct {
    int            row;
    int            col;
    logic [DW-1:0] data;
  } wr_t;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] ref_elem(input int op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [63:0] p;
    case (op)
      0: p = {32'd0, a} + {32'd0, b};
      1: p = {32'd0, a} + (64'd1 << DW) - {32'd0, b};
      2: p = {32'd0, a} * {32'd0, b};
      3: p = (b == 0) ? 64'hFFFF_FFFF : {32'd0, a / b};
      4: p = (b == 0) ? {32'd0, a} : {32'd0, a % b};
      default: p = 64'd0;
    endcase
    return p[DW-1:0];
  endfunction

  // Matrix store: data for a read shows up one cycle later; otherwise noise.
  initial begin
    logic           hit;
    logic [WB-1:0]  r, c;
    bus.rd_a_data = '0;
    bus.rd_b_data = '0;
    forever begin
      @(negedge clk);
      hit = bus.rd_en;
      r   = bus.rd_row;
      c   = bus.rd_col;
      @(posedge clk);
      #1;
      if (hit) begin
        bus.rd_a_data = mem_a[r][c];
        bus.rd_b_data = mem_b[r][c];
      end else begin
        bus.rd_a_data = $urandom;
        bus.rd_b_data = $urandom;
      end
    end
  end

  task automatic drive_cmd(input int op, input int ra, input int ca, input int rb, input int cb);
    bus.cmd_op        = 3'(op);
    bus.cmd_size_a[0] = WB'(ra);
    bus.cmd_size_a[1] = WB'(ca);
    bus.cmd_size_b[0] = WB'(rb);
    bus.cmd_size_b[1] = WB'(cb);
    bus.cmd_valid     = 1'b1;
  endtask

  // Called at a falling edge; the current cycle is the accept cycle (cycle 0).
  task automatic run_cmd(input int op, input int ra, input int ca, input int rb, input int cb,
                         input bit hold_next, input bit expect_imm);
    wr_t exp_q[$];
    int  exp_err, exp_done, exp_rd, n_elem, abort_at, waited, rd_cnt, wr_cnt;
    bit  seen_done;
    exp_err  = 0;
    abort_at = -1;
    if (ra != rb || ca != cb) exp_err = 1;
    else if (op > 4)          exp_err = 2;
    n_elem = (exp_err == 0) ? (ra + 1) * (ca + 1) : 0;
    exp_rd = n_elem;
    for (int k = 0; k < n_elem; k++) begin
      int  r, c;
      bit  z;
      r = k / (ca + 1);
      c = k % (ca + 1);
      z = (op == 3 || op == 4) && (mem_b[r][c] == 0);
      if (z) exp_err = 3;
`ifdef ELEMENT_OP_DIV0_ABORT_EN
      if (z && abort_at < 0) begin
        abort_at = k;
        exp_rd   = k + 1;
      end
      if (abort_at < 0) exp_q.push_back('{r, c, ref_elem(op, mem_a[r][c], mem_b[r][c])});
`else
      exp_q.push_back('{r, c, ref_elem(op, mem_a[r][c], mem_b[r][c])});
`endif
    end
    if (exp_err == 1 || exp_err == 2) exp_done = 1;
    else if (abort_at >= 0)           exp_done = abort_at + 3;
    else                              exp_done = n_elem + 2;

    drive_cmd(op, ra, ca, rb, cb);
    waited = 0;
    while (!bus.cmd_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (expect_imm) chk("b2b_accept_wait", waited, 0);
    if (!bus.cmd_ready) chk("accept_timeout", 0, 1);

    rd_cnt    = 0;
    wr_cnt    = 0;
    seen_done = 1'b0;
    for (int n = 1; n <= 100 && !seen_done; n++) begin
      @(negedge clk);
      chk("busy", bus.busy, 1);
      chk("cmd_ready_low", bus.cmd_ready, 0);
      if (bus.rd_en) begin
        chk("rd_cycle", n, rd_cnt + 1);
        chk("rd_idx", {bus.rd_row, bus.rd_col}, {WB'(rd_cnt / (ca + 1)), WB'(rd_cnt % (ca + 1))});
        rd_cnt++;
      end
      if (bus.wr_en) begin
        if (wr_cnt < exp_q.size()) begin
          chk("wr_cycle", n, wr_cnt + 2);
          chk("wr_idx", {bus.wr_row, bus.wr_col}, {WB'(exp_q[wr_cnt].row), WB'(exp_q[wr_cnt].col)});
          chk("wr_data", bus.wr_data, exp_q[wr_cnt].data);
        end
        wr_cnt++;
      end
      if (bus.done) begin
        seen_done = 1'b1;
        chk("done_cycle", n, exp_done);
        chk("err_code", bus.err_code, exp_err);
        chk("rd_count", rd_cnt, exp_rd);
        chk("wr_count", wr_cnt, exp_q.size());
      end
      if (n == 1) begin
        if (hold_next) drive_cmd(nxt_op, nxt_ra, nxt_ca, nxt_rb, nxt_cb);
        else           bus.cmd_valid = 1'b0;
      end
    end
    if (!seen_done) chk("done_timeout", 0, 1);

    @(negedge clk);
    chk("idle_ready", bus.cmd_ready, 1);
    chk("idle_busy", bus.busy, 0);
    chk("done_pulse_len", bus.done, 0);
    chk("err_hold", bus.err_code, exp_err);
  endtask

  task automatic rst_test();
    int wr_seen;
    wr_seen = 0;
    for (int i = 0; i < W; i++)
      for (int j = 0; j < W; j++) begin
        mem_a[i][j] = $urandom;
        mem_b[i][j] = $urandom;
      end
    drive_cmd(0, 3, 3, 3, 3);
    chk("rst_pre_ready", bus.cmd_ready, 1);
    for (int n = 1; n <= 5; n++) begin
      @(negedge clk);
      if (n == 1) bus.cmd_valid = 1'b0;
      if (bus.wr_en) wr_seen++;
    end
    rst = 1'b1;
    #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_rd_en", bus.rd_en, 0);
    chk("rst_wr_en", bus.wr_en, 0);
    chk("rst_cmd_ready", bus.cmd_ready, 1);
    chk("rst_done", bus.done, 0);
    chk("rst_partial_writes", wr_seen, 4);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("post_rst_quiet", {bus.rd_en, bus.wr_en, bus.done, bus.busy}, 4'b0000);
    end
  endtask

  initial begin
    int op, ra, ca, rb, cb;
    rst           = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_size_a = '0;
    bus.cmd_size_b = '0;
    repeat (2) @(negedge clk);
    chk("reset_cmd_ready", bus.cmd_ready, 1);
    chk("reset_busy", bus.busy, 0);
    chk("reset_done", bus.done, 0);
    chk("reset_rd_en", bus.rd_en, 0);
    chk("reset_wr_en", bus.wr_en, 0);
    chk("reset_err", bus.err_code, 0);
    chk("reset_idx", {bus.rd_row, bus.rd_col, bus.wr_row, bus.wr_col}, 8'h00);
    chk("reset_wr_data", bus.wr_data, 0);
    rst = 1'b0;
    @(negedge clk);

    // Add 2x3, A=i*10+j, B=1.
    for (int i = 0; i < W; i++)
      for (int j = 0; j < W; j++) begin
        mem_a[i][j] = i * 10 + j;
        mem_b[i][j] = 1;
      end
    run_cmd(0, 1, 2, 1, 2, 0, 0);

    // Sub 1x1 wraps to all-ones.
    mem_a[0][0] = 0;
    mem_b[0][0] = 1;
    run_cmd(1, 0, 0, 0, 0, 0, 0);

    // Size mismatch, then illegal op.
    run_cmd(0, 1, 1, 1, 2, 0, 0);
    run_cmd(6, 1, 1, 1, 1, 0, 0);

    // Div 2x2 with one zero divisor.
    for (int i = 0; i < W; i++)
      for (int j = 0; j < W; j++) mem_a[i][j] = 100;
    mem_b[0][0] = 5;
    mem_b[0][1] = 0;
    mem_b[1][0] = 3;
    mem_b[1][1] = 4;
    run_cmd(3, 1, 1, 1, 1, 0, 0);

    // Mod 4x4 followed back-to-back by a held mul.
    for (int i = 0; i < W; i++)
      for (int j = 0; j < W; j++) begin
        mem_a[i][j] = 32'hFFFF_FFFF;
        mem_b[i][j] = 7;
      end
    nxt_op = 2; nxt_ra = 0; nxt_ca = 0; nxt_rb = 0; nxt_cb = 0;
    run_cmd(4, 3, 3, 3, 3, 1, 0);
    mem_a[0][0] = 32'h0001_0000;
    mem_b[0][0] = 32'h0001_0000;
    run_cmd(2, 0, 0, 0, 0, 0, 1);

    rst_test();

    for (int t = 0; t < 25; t++) begin
      op = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 4)) : int'($urandom_range(5, 7));
      ra = $urandom_range(0, 3);
      ca = $urandom_range(0, 3);
      if ($urandom_range(0, 9) < 8) begin
        rb = ra;
        cb = ca;
      end else begin
        rb = $urandom_range(0, 3);
        cb = $urandom_range(0, 3);
      end
      for (int i = 0; i < W; i++)
        for (int j = 0; j < W; j++) begin
          mem_a[i][j] = $urandom;
          if ($urandom_range(0, 7) == 0)      mem_b[i][j] = 0;
          else if ($urandom_range(0, 1) == 1) mem_b[i][j] = $urandom_range(1, 20);
          else                                mem_b[i][j] = $urandom;
        end
      run_cmd(op, ra, ca, rb, cb, 0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
